imm_gen_pipe: RTL and testbench

Pipelined, multi-lane immediate generator for the ID stage. Each cycle it accepts a bundle of up to FETCH_WIDTH 32-bit RV32I instruction words and returns, one cycle later, a sign- or zero-extended immediate, a format code and an illegal-opcode flag per lane. It decodes all base formats (R/I/S/B/U/J), including shift-amount handling. A 2-entry skid buffer with valid/ready handshaking on both sides lets rename back-pressure decode without dropping bundles.

---
 rtl/imm_gen_pipe.sv | 175 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Multi-lane RV32I immediate generator with a registered output stage and a
// one-entry skid register, so rename can stall decode without losing bundles.
module imm_gen_pipe #(
  parameter int FETCH_WIDTH = 2,
  parameter int IMM_WIDTH   = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [FETCH_WIDTH-1:0]           in_lane_valid,
  input  logic [FETCH_WIDTH*32-1:0]        in_instr,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [FETCH_WIDTH*IMM_WIDTH-1:0] out_imm,
  output logic [FETCH_WIDTH*3-1:0]         out_fmt,
  output logic [FETCH_WIDTH-1:0]           out_illegal,
  output logic [CNT_WIDTH-1:0]             illegal_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
    FMT_U = 3'd4, FMT_J = 3'd5, FMT_NONE = 3'd7
  } fmt_e;

  state_e                           state_q;
  logic                             in_ready_q, out_valid_q;
  logic [FETCH_WIDTH*IMM_WIDTH-1:0] out_imm_q, skid_imm_q, imm_d;
  logic [FETCH_WIDTH*3-1:0]         out_fmt_q, skid_fmt_q, fmt_d;
  logic [FETCH_WIDTH-1:0]           out_ill_q, skid_ill_q, ill_d;
  logic [CNT_WIDTH-1:0]             cnt_q, cnt_d;
  logic                             acc, drn;

  function automatic logic [IMM_WIDTH-1:0] sext32(input logic [31:0] v);
    return IMM_WIDTH'($signed(v));
  endfunction

  always_comb begin
    logic [31:0]          ins;
    logic [IMM_WIDTH-1:0] imm;
    fmt_e                 fmt;
    logic                 ill;
    imm_d = '0;
    fmt_d = '0;
    ill_d = '0;
    ins   = '0;
    imm   = '0;
    fmt   = FMT_NONE;
    ill   = 1'b0;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      ins = in_instr[32*i +: 32];
      imm = '0;
      fmt = FMT_NONE;
      ill = 1'b0;
      if (in_lane_valid[i]) begin
        case (ins[6:0])
          7'b0110011: fmt = FMT_R;
          7'b0000011, 7'b1100111: begin
            fmt = FMT_I;
            imm = sext32({{20{ins[31]}}, ins[31:20]});
          end
          7'b0010011: begin
            fmt = FMT_I;
            // Shifts carry funct7 in the upper immediate bits; only the shamt survives.
            if (ins[13:12] == 2'b01)
              imm = (IMM_WIDTH == 64) ? IMM_WIDTH'(ins[25:20]) : IMM_WIDTH'(ins[24:20]);
            else
              imm = sext32({{20{ins[31]}}, ins[31:20]});
          end
          7'b0100011: begin
            fmt = FMT_S;
            imm = sext32({{20{ins[31]}}, ins[31:25], ins[11:7]});
          end
          7'b1100011: begin
            fmt = FMT_B;
            imm = sext32({{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
          end
          7'b0110111, 7'b0010111: begin
            fmt = FMT_U;
            imm = sext32({ins[31:12], 12'h000});
          end
          7'b1101111: begin
            fmt = FMT_J;
            imm = sext32({{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
          end
          default: ill = 1'b1;
        endcase
      end
      imm_d[IMM_WIDTH*i +: IMM_WIDTH] = imm;
      fmt_d[3*i +: 3]                 = fmt;
      ill_d[i]                        = ill;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      if (out_ill_q[i] && cnt_d != '1)
        cnt_d = cnt_d + CNT_WIDTH'(1);
    end
  end

  assign acc = in_valid & in_ready_q;
  assign drn = out_valid_q & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_fmt_q   <= '0;
      out_ill_q   <= '0;
      skid_imm_q  <= '0;
      skid_fmt_q  <= '0;
      skid_ill_q  <= '0;
      cnt_q       <= '0;
    end else if (flush) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: if (acc) begin
          out_imm_q   <= imm_d;
          out_fmt_q   <= fmt_d;
          out_ill_q   <= ill_d;
          out_valid_q <= 1'b1;
          state_q     <= ONE;
        end
        ONE: begin
          if (drn) cnt_q <= cnt_d;
          if (acc && drn) begin
            out_imm_q <= imm_d;
            out_fmt_q <= fmt_d;
            out_ill_q <= ill_d;
          end else if (acc) begin
            skid_imm_q <= imm_d;
            skid_fmt_q <= fmt_d;
            skid_ill_q <= ill_d;
            in_ready_q <= 1'b0;
            state_q    <= FULL;
          end else if (drn) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: if (drn) begin
          cnt_q      <= cnt_d;
          out_imm_q  <= skid_imm_q;
          out_fmt_q  <= skid_fmt_q;
          out_ill_q  <= skid_ill_q;
          in_ready_q <= 1'b1;
          state_q    <= ONE;
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_ill_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit/4-bit-counter instance and a 64-bit instance
// share stimulus and are checked each cycle against a queue-based reference.
module tb_imm_gen_pipe;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, out_ready;
  logic [1:0]   in_lane_valid;
  logic [63:0]  in_instr;

  logic         rdy32, vld32, rdy64, vld64;
  logic [63:0]  imm32;
  logic [127:0] imm64;
  logic [5:0]   fmt32, fmt64;
  logic [1:0]   ill32, ill64;
  logic [3:0]   cnt32;
  logic [15:0]  cnt64;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.FETCH_WIDTH(2), .IMM_WIDTH(32), .CNT_WIDTH(4)) u32 (
    .clk(clk), .reset_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_lane_valid(in_lane_valid), .in_instr(in_instr), .out_valid(vld32),
    .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32),
    .illegal_cnt(cnt32));

  imm_gen_pipe #(.FETCH_WIDTH(2), .IMM_WIDTH(64), .CNT_WIDTH(16)) u64 (
    .clk(clk), .reset_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_lane_valid(in_lane_valid), .in_instr(in_instr), .out_valid(vld64),
    .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64),
    .illegal_cnt(cnt64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the RV32I immediate layouts.
  function automatic void model_lane(input logic [31:0] ins, input logic v, input bit w64,
                                     output logic [63:0] imm, output logic [2:0] fmt,
                                     output logic ill);
    imm = '0; fmt = 3'd7; ill = 1'b0;
    if (!v) return;
    case (ins[6:0])
      7'h33: fmt = 3'd0;
      7'h03, 7'h67: begin fmt = 3'd1; imm = longint'($signed(ins[31:20])); end
      7'h13: begin
        fmt = 3'd1;
        if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101)
          imm = w64 ? 64'(ins[25:20]) : 64'(ins[24:20]);
        else
          imm = longint'($signed(ins[31:20]));
      end
      7'h23: begin fmt = 3'd2; imm = longint'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin fmt = 3'd3; imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); end
      7'h37, 7'h17: begin fmt = 3'd4; imm = longint'($signed({ins[31:12], 12'h000})); end
      7'h6F: begin fmt = 3'd5; imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
      default: ill = 1'b1;
    endcase
  endfunction

  typedef struct {
    logic [63:0] instr;
    logic [1:0]  lv;
  } bundle_t;

  bundle_t     q[$];
  int unsigned mcnt32, mcnt64;

  always @(posedge clk or negedge rst_n) begin
    int          sz;
    bundle_t     b;
    logic [63:0] e;
    logic [2:0]  ef;
    logic        ei;
    if (!rst_n) begin
      q.delete();
      mcnt32 = 0;
      mcnt64 = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      sz = q.size();
      if (sz > 0 && out_ready) begin
        b = q.pop_front();
        for (int i = 0; i < 2; i++) begin
          model_lane(b.instr[32*i +: 32], b.lv[i], 1'b0, e, ef, ei);
          if (ei) begin
            if (mcnt32 < 15) mcnt32++;
            if (mcnt64 < 65535) mcnt64++;
          end
        end
      end
      if (in_valid && sz < 2) q.push_back('{in_instr, in_lane_valid});
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    logic [2:0]  ef;
    logic        ei;
    chk("in_ready32", 64'(rdy32), 64'(q.size() < 2));
    chk("in_ready64", 64'(rdy64), 64'(q.size() < 2));
    chk("out_valid32", 64'(vld32), 64'(q.size() > 0));
    chk("out_valid64", 64'(vld64), 64'(q.size() > 0));
    chk("cnt32", 64'(cnt32), 64'(mcnt32));
    chk("cnt64", 64'(cnt64), 64'(mcnt64));
    if (q.size() > 0) begin
      for (int i = 0; i < 2; i++) begin
        model_lane(q[0].instr[32*i +: 32], q[0].lv[i], 1'b0, e, ef, ei);
        chk("imm32", 64'(imm32[32*i +: 32]), 64'(e[31:0]));
        chk("fmt32", 64'(fmt32[3*i +: 3]), 64'(ef));
        chk("ill32", 64'(ill32[i]), 64'(ei));
        model_lane(q[0].instr[32*i +: 32], q[0].lv[i], 1'b1, e, ef, ei);
        chk("imm64", imm64[64*i +: 64], e);
        chk("fmt64", 64'(fmt64[3*i +: 3]), 64'(ef));
        chk("ill64", 64'(ill64[i]), 64'(ei));
      end
    end
  end

  task automatic drive(input logic [31:0] l0, input logic [31:0] l1, input logic [1:0] lv,
                       input logic v);
    in_instr      = {l1, l0};
    in_lane_valid = lv;
    in_valid      = v;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_imm32"}, imm32, 64'h0);
    chk({tag, "_imm64_lo"}, imm64[63:0], 64'h0);
    chk({tag, "_imm64_hi"}, imm64[127:64], 64'h0);
    chk({tag, "_fmt"}, 64'({fmt32, fmt64}), 64'h0);
    chk({tag, "_ill"}, 64'({ill32, ill64}), 64'h0);
    chk({tag, "_cnt"}, 64'({cnt32, cnt64}), 64'h0);
    chk({tag, "_vld"}, 64'({vld32, vld64}), 64'h0);
    chk({tag, "_rdy"}, 64'({rdy32, rdy64}), 64'h3);
  endtask

  logic [31:0] tbl [12] = '{32'hFFF00093, 32'hFE000EE3, 32'h123452B7, 32'h001000EF,
                            32'h00309093, 32'h4040D093, 32'h0000007F, 32'h0020A423,
                            32'h002081B3, 32'hFFFFF2B7, 32'h8000006F, 32'h02109093};

  initial begin
    logic [63:0] e;
    logic [2:0]  ef;
    logic        ei;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(32'h0, 32'h0, 2'b00, 1'b0);

    model_lane(32'h02109093, 1'b1, 1'b1, e, ef, ei);
    chk("model_slli33_64", e, 64'd33);
    model_lane(32'h8000006F, 1'b1, 1'b0, e, ef, ei);
    chk("model_jal_neg", e, 64'hFFFF_FFFF_FFF0_0000);

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    drive(32'hFFF00093, 32'hFE000EE3, 2'b11, 1'b1);
    step();
    chk("addi_valid", 64'(vld32), 64'd1);
    chk("addi_imm", 64'(imm32[31:0]), 64'hFFFFFFFF);
    chk("beq_imm", 64'(imm32[63:32]), 64'hFFFFFFFC);
    chk("addi_beq_fmt", 64'(fmt32), 64'({3'd3, 3'd1}));

    drive(32'h123452B7, 32'h001000EF, 2'b11, 1'b1);
    step();
    chk("lui_imm", 64'(imm32[31:0]), 64'h12345000);
    chk("jal_imm", 64'(imm32[63:32]), 64'h00000800);
    chk("lui_jal_fmt", 64'(fmt32), 64'({3'd5, 3'd4}));

    drive(32'hFFFFF2B7, 32'h00309093, 2'b11, 1'b1);
    step();
    chk("lui64_imm", imm64[63:0], 64'hFFFFFFFFFFFFF000);
    chk("lui32_imm", 64'(imm32[31:0]), 64'hFFFFF000);
    chk("slli_imm", 64'(imm32[63:32]), 64'd3);

    drive(32'h4040D093, 32'h0020A423, 2'b11, 1'b1);
    step();
    chk("srai_imm", 64'(imm32[31:0]), 64'd4);
    chk("srai_fmt", 64'(fmt32[2:0]), 64'd1);
    chk("sw_imm", 64'(imm32[63:32]), 64'd8);

    drive(32'h0000007F, 32'hFFF00093, 2'b01, 1'b1);
    step();
    chk("illegal_flags", 64'(ill32), 64'b01);
    chk("illegal_fmt", 64'(fmt32), 64'({3'd7, 3'd7}));
    chk("illegal_imm", imm32, 64'h0);
    drive(32'h0, 32'h0, 2'b00, 1'b0);
    step();
    chk("illegal_cnt_1", 64'(cnt32), 64'd1);

    repeat (8) begin
      drive(32'h0000007F, 32'h0000007F, 2'b11, 1'b1);
      step();
    end
    drive(32'h0, 32'h0, 2'b00, 1'b0);
    step();
    chk("cnt32_saturated", 64'(cnt32), 64'd15);
    chk("cnt64_17", 64'(cnt64), 64'd17);

    out_ready = 1'b0;
    drive(32'h00100093, 32'h00100093, 2'b11, 1'b1);
    step();
    chk("bp_A_out", 64'(imm32[31:0]), 64'd1);
    drive(32'h00200093, 32'h00200093, 2'b11, 1'b1);
    step();
    chk("bp_full_rdy", 64'(rdy32), 64'd0);
    drive(32'h00300093, 32'h00300093, 2'b11, 1'b1);
    step();
    step();
    chk("bp_A_held", 64'(imm32[31:0]), 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp_B_out", 64'(imm32[31:0]), 64'd2);
    chk("bp_rdy_back", 64'(rdy32), 64'd1);
    step();
    chk("bp_C_out", 64'(imm32[31:0]), 64'd3);
    drive(32'h0, 32'h0, 2'b00, 1'b0);
    step();
    chk("bp_empty", 64'(vld32), 64'd0);

    out_ready = 1'b0;
    drive(32'h0000007F, 32'h0000007F, 2'b11, 1'b1);
    step();
    drive(32'h00500093, 32'h00500093, 2'b11, 1'b1);
    step();
    chk("fl_full_rdy", 64'(rdy32), 64'd0);
    flush = 1'b1;
    drive(32'h00600093, 32'h00600093, 2'b11, 1'b1);
    step();
    chk("fl_vld", 64'(vld32), 64'd0);
    chk("fl_rdy", 64'(rdy32), 64'd1);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(32'h0, 32'h0, 2'b00, 1'b0);
    step();
    step();
    chk("fl_no_stale", 64'(vld32), 64'd0);
    chk("fl_cnt64", 64'(cnt64), 64'd17);

    for (int k = 0; k < 60; k++) begin
      drive(tbl[$urandom_range(0, 11)], tbl[$urandom_range(0, 11)],
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      if (k == 40) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
      end
      step();
    end
    flush = 1'b0;
    drive(32'h0, 32'h0, 2'b00, 1'b0);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
